// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer (99..00).
//
// A preset is captured with load. start begins or resumes counting, and stop pauses it.
// Each en tick in RUN decrements the count by one. done pulses for one cycle when the
// count reaches 00. When RELOAD != 0, the next tick at 00 reloads the preset and counting
// continues. Otherwise the timer returns to IDLE on the edge that produces 00.
//
// Ports:
//   clk1     in   system clock, rising edge
//   rst1     in   asynchronous active-low reset
//   en       in   count tick enable
//   load     in   capture ld_tens/ld_ones as preset and current count
//   ld_ones  in   preset ones digit (BCD, >9 saturates to 9)
//   ld_tens  in   preset tens digit (BCD, >9 saturates to 9)
//   start    in   begin or resume counting
//   stop     in   pause counting
//   ones     out  current ones digit
//   tens     out  current tens digit
//   busy     out  high in RUN or HOLD
//   done     out  registered one-cycle pulse while the count first shows 00
//   zero     out  combinational, count == 00
module bcd_down_timer #(
  parameter int unsigned RELOAD = 0
) (
  input  logic       clk1,
  input  logic       rst1,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] ld_ones,
  input  logic [3:0] ld_tens,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       busy,
  output logic       done,
  output logic       zero
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] pre_ones_q, pre_ones_d;
  logic [3:0] pre_tens_q, pre_tens_d;
  logic       done_q, done_d;

  logic       cnt_zero;
  logic       last_step;  // count is 01, so the next tick lands on 00
  logic [3:0] sat_ones;
  logic [3:0] sat_tens;

  function automatic logic [3:0] sat_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign sat_ones  = sat_bcd(ld_ones);
  assign sat_tens  = sat_bcd(ld_tens);
  assign cnt_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign last_step = (tens_q == 4'd0) && (ones_q == 4'd1);

  // Priority: load > stop > start > en. A start in any state consumes the cycle, so an en
  // tick in the same cycle is dropped.
  always_comb begin
    state_d    = state_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    pre_ones_d = pre_ones_q;
    pre_tens_d = pre_tens_q;
    done_d     = 1'b0;

    if (load) begin
      pre_ones_d = sat_ones;
      pre_tens_d = sat_tens;
      ones_d     = sat_ones;
      tens_d     = sat_tens;
      state_d    = StIdle;
    end else if (stop) begin
      if (state_q != StIdle) begin
        state_d = StHold;
      end
    end else if (start) begin
      unique case (state_q)
        StIdle: begin
          // Starting from 00 would immediately underflow, so it is ignored.
          if (!cnt_zero) begin
            state_d = StRun;
          end
        end
        StHold:  state_d = StRun;
        StRun:   state_d = StRun;
        default: state_d = StIdle;
      endcase
    end else if (en && (state_q == StRun)) begin
      if (cnt_zero) begin
        // Only reachable while auto-reloading; otherwise we already left RUN at 00.
        if (RELOAD != 0) begin
          ones_d = pre_ones_q;
          tens_d = pre_tens_q;
        end else begin
          state_d = StIdle;
        end
      end else if (ones_q != 4'd0) begin
        ones_d = ones_q - 4'd1;
        if (last_step) begin
          done_d = 1'b1;
          if (RELOAD == 0) begin
            state_d = StIdle;
          end
        end
      end else begin
        // Borrow from tens.
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst1) begin
    if (!rst1) begin
      state_q    <= StIdle;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      pre_ones_q <= 4'd0;
      pre_tens_q <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      pre_ones_q <= pre_ones_d;
      pre_tens_q <= pre_tens_d;
      done_q     <= done_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign zero = cnt_zero;

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Two-digit BCD countdown timer (99..00), the down-counting counterpart of the team's 00..99 BCD up counter.
- A preset value is loaded, counting is started, and the count decrements one step per enable tick.
- Counting can be paused and resumed; a one-cycle done pulse fires when the count reaches 00.
- Sits between the tick divider and the seven-segment digit mux, the same place the up counter sits.

Parameters:
RELOAD, 0, 0 = stop at 00 and return to IDLE; 1 = auto-reload the preset after 00 and keep running

Ports:
clk1  input  1  system clock, rising-edge
rst1  input  1  asynchronous, active-low reset
en  input  1  count tick enable, one decrement per clk1 edge while high in RUN
load  input  1  capture ld_tens/ld_ones as preset and current count
ld_ones  input  4  preset ones digit, BCD
ld_tens  input  4  preset tens digit, BCD
start  input  1  begin or resume counting
stop  input  1  pause counting
ones  output  4  current ones digit, BCD
tens  output  4  current tens digit, BCD
busy  output  1  high in RUN or HOLD
done  output  1  registered one-cycle pulse on reaching 00
zero  output  1  combinational, (tens==0 && ones==0)

Behaviour:
- Reset (rst1 low, any time, asynchronous):
  - ones=0, tens=0, preset registers=00.
  - State goes to IDLE; busy=0, done=0, zero=1.
  - A run in progress is abandoned with no done pulse.
- States: IDLE, RUN, HOLD. busy = (state != IDLE).
- Priority at each edge: load > stop > start > en.
- load, from any state:
  - Preset and count both take ld_tens/ld_ones.
  - Any digit > 9 saturates to 9.
  - State goes to IDLE; done=0 that cycle.
  - The en tick in the same cycle is ignored.
- IDLE:
  - start with count != 00 goes to RUN.
  - start with count == 00 is ignored; state stays IDLE.
  - en is ignored; stop has no effect.
- RUN, each edge with en=1:
  - ones>0: ones-1.
  - ones==0 and tens>0: ones=9, tens-1 (borrow).
  - Count 01 -> 00: done=1 on the following cycle only (done is high while count shows 00).
  - RELOAD=0: state goes to IDLE on the same edge that produces 00.
  - RELOAD=1: state stays RUN; the next en tick at 00 loads the preset; done pulses every time 00 is reached.
- RUN with en=0: count holds.
- stop in RUN goes to HOLD; count frozen.
- HOLD:
  - en is ignored.
  - start returns to RUN; counting resumes on the next en tick.
  - stop has no effect.
- start and stop in the same cycle: stop wins, so RUN or HOLD goes to HOLD, and IDLE stays IDLE.
- done never asserts for a load of 00, or for reset.
- Outputs are always valid BCD (0..9); no wrap below 00.
- Latency:
  - Count update is visible one edge after the tick.
  - done is visible in the cycle after count reaches 00.
  - zero has zero latency.

Test Plan:
- Basic countdown (RELOAD=0): load 12, start, en held high -> 12,11,10,09,...,01,00; done high exactly one cycle coincident with 00; busy=0 afterwards; extra en ticks leave 00.
- Borrow and saturation: load 30, start, one tick -> 29. load ld_tens=12, ld_ones=15 -> 99. load 00 then start -> busy stays 0, done stays 0.
- Pause/resume:
  - load 05, start, 2 ticks -> 03.
  - stop, 5 ticks -> 03, busy=1.
  - start, 1 tick -> 02.
  - start and stop asserted together -> HOLD, count stays 02.
- Load mid-run: load 25, start, 3 ticks -> 22; load 40 -> count 40, IDLE, busy=0, en ticks have no effect until start.
- Async reset mid-run: load 25, start, 3 ticks -> 22; drive rst1 low between edges -> immediately 00, zero=1, busy=0, done=0; after release, start is ignored (count 00).
- Auto-reload (RELOAD=1): load 02, start, continuous en -> 02,01,00(done),02,01,00(done); busy stays 1 throughout; stop then freezes the count.
